// File: rtl/mips_mc_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_ctrl_pkg
//  Brief    : Shared types and constants for the multi-cycle MIPS controller:
//             FSM state encoding, opcode/funct values, ALU op classes and
//             ALU control codes.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // FSM states; the numeric codes are visible on state_dbg.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // ALU operation class chosen by the FSM and refined by alu_decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  // Supported opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  // Supported R-type funct codes (instr[5:0]).
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALU control codes understood by the datapath ALU.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True when an R-type funct is one the datapath can execute.
  function automatic logic funct_supported(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mc_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_controller_if
//  Brief    : Bundle between the controller and the datapath: instruction
//             fields and zero flag in, mux selects and write enables out.
//  Revision : 1.0 - initial release
// ============================================================================
interface mips_mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       pc_en;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] pc_src;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  // Controller side: consumes instruction fields, drives control.
  modport master (
    input  opcode, funct, zero_flag,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, illegal_instr, state_dbg
  );

  // Datapath side: supplies instruction fields, obeys control.
  modport slave (
    output opcode, funct, zero_flag,
    input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_control, pc_src, illegal_instr, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/mips_mc_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Brief    : Maps the FSM's ALU op class plus the R-type funct field to the
//             3-bit ALU control code. Purely combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Select the ALU operation; unknown funct values fall back to ADD.
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_controller
//  Brief    : Multi-cycle MIPS control FSM. Steps each instruction through
//             fetch/decode/execute states, drives datapath selects and write
//             enables, and resolves beq from the ALU zero flag.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mc_controller
  import mips_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  mips_mc_controller_if.master bus
);

  state_t     state;
  state_t     state_next;
  aluop_t     aluop;
  logic       pc_write;
  logic       branch;
  logic       ir_write_st;
  logic       mem_write_st;
  logic       reg_write_st;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       illegal;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_next   = S_FETCH;
    pc_write     = 1'b0;
    branch       = 1'b0;
    ir_write_st  = 1'b0;
    mem_write_st = 1'b0;
    reg_write_st = 1'b0;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    aluop        = ALUOP_ADD;
    illegal      = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write_st = 1'b1;
        pc_write    = 1'b1;
        alu_src_b   = 2'b01;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded.
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE: begin
            if (funct_supported(bus.funct)) begin
              state_next = S_EXECUTE;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_BEQ:  state_next = S_BRANCH;
          OP_ADDI: state_next = S_ADDIEXEC;
          OP_J:    state_next = S_JUMP;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg   = 1'b1;
        reg_write_st = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        mem_write_st = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst      = 1'b1;
        reg_write_st = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_st = 1'b1;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct       (bus.funct),
    .alu_control (bus.alu_control)
  );

  // Enables are gated by rst_n so nothing writes while reset is held,
  // even though FETCH (whose outputs are otherwise visible) asserts them.
  assign bus.pc_en         = rst_n & (pc_write | (branch & bus.zero_flag));
  assign bus.ir_write      = rst_n & ir_write_st;
  assign bus.mem_write     = rst_n & mem_write_st;
  assign bus.reg_write     = rst_n & reg_write_st;
  assign bus.iord          = iord;
  assign bus.reg_dst       = reg_dst;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.pc_src        = pc_src;
  assign bus.illegal_instr = illegal;
  assign bus.state_dbg     = state;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_mc_controller
//  Brief    : Self-checking bench for mips_mc_controller. Directed cases plus
//             random instruction streams compared against a cycle-by-cycle
//             reference built from the instruction-class rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_controller;

  localparam int C_LW   = 0;
  localparam int C_SW   = 1;
  localparam int C_R    = 2;
  localparam int C_ADDI = 3;
  localparam int C_BEQ  = 4;
  localparam int C_J    = 5;
  localparam int C_ILL  = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_mc_controller_if bus();

  mips_mc_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Observed control bundle, bit layout shared with ref_out.
  logic [15:0] obs_out;
  assign obs_out = {bus.pc_en, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                    bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                    bus.alu_control, bus.pc_src, bus.illegal_instr};

  function automatic logic [15:0] pack(logic pc_en, logic iord, logic mw, logic irw,
                                       logic rd, logic m2r, logic rw, logic sa,
                                       logic [1:0] sb, logic [2:0] alu,
                                       logic [1:0] ps, logic ill);
    return {pc_en, iord, mw, irw, rd, m2r, rw, sa, sb, alu, ps, ill};
  endfunction

  function automatic logic [2:0] ref_alu_r(logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic int latency(int cls);
    case (cls)
      C_LW:    return 5;
      C_SW, C_R, C_ADDI: return 4;
      C_BEQ, C_J: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected state code for cycle c of an instruction of class cls.
  function automatic logic [3:0] ref_state(int cls, int c);
    int seq[5];
    case (cls)
      C_LW:    seq = '{0, 1, 2, 3, 4};
      C_SW:    seq = '{0, 1, 2, 5, 0};
      C_R:     seq = '{0, 1, 6, 7, 0};
      C_ADDI:  seq = '{0, 1, 9, 10, 0};
      C_BEQ:   seq = '{0, 1, 8, 0, 0};
      C_J:     seq = '{0, 1, 11, 0, 0};
      default: seq = '{0, 1, 0, 0, 0};
    endcase
    return 4'(seq[c]);
  endfunction

  // Expected control bundle for cycle c of an instruction.
  function automatic logic [15:0] ref_out(int cls, int c, logic [5:0] f, logic z);
    if (c == 0) return pack(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
    if (c == 1) return pack(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, cls == C_ILL);
    case (cls)
      C_LW: begin
        if (c == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        if (c == 3) return pack(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0);
        return pack(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0);
      end
      C_SW: begin
        if (c == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        return pack(0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0);
      end
      C_R: begin
        if (c == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ref_alu_r(f), 2'b00, 0);
        return pack(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0);
      end
      C_ADDI: begin
        if (c == 2) return pack(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
        return pack(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0);
      end
      C_BEQ:   return pack(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0);
      C_J:     return pack(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 0);
      default: return 16'h0;
    endcase
  endfunction

  localparam logic [15:0] RESET_OUT = 16'h0050; // alu_src_b=01, alu_control=ADD

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from its FETCH cycle. zmode 0/1 forces zero_flag
  // in the BRANCH cycle, 2 leaves it random. abort_at>=0 asserts reset
  // right after that cycle is checked.
  task automatic run_instr(int cls, logic [5:0] op, logic [5:0] f, int zmode, int abort_at);
    bus.opcode    = op;
    bus.funct     = f;
    bus.zero_flag = 1'($urandom_range(0, 1));
    #1;
    for (int c = 0; c < latency(cls); c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        bus.zero_flag = 1'($urandom_range(0, 1));
        if (cls == C_BEQ && c == 2 && zmode != 2) bus.zero_flag = (zmode == 1);
        #1;
      end
      check($sformatf("state op=%h f=%h cyc=%0d", op, f, c),
            {12'h0, bus.state_dbg}, {12'h0, ref_state(cls, c)});
      check($sformatf("ctrl op=%h f=%h cyc=%0d", op, f, c),
            obs_out, ref_out(cls, c, f, bus.zero_flag));
      if (c == abort_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("abort state", {12'h0, bus.state_dbg}, 16'h0);
        check("abort ctrl", obs_out, RESET_OUT);
        @(posedge clk);
        #1;
        check("abort held ctrl", obs_out, RESET_OUT);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] legal_f [5];
    logic [5:0] op;
    logic [5:0] f;
    int         sel;
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    bus.opcode    = 6'h00;
    bus.funct     = 6'h20;
    bus.zero_flag = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset state", {12'h0, bus.state_dbg}, 16'h0);
    check("reset ctrl", obs_out, RESET_OUT);
    bus.zero_flag = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset held ctrl", obs_out, RESET_OUT);
    @(negedge clk);
    rst_n = 1'b1;

    // sw aborted in MEMWR, then a clean instruction stream follows.
    run_instr(C_SW, 6'h2B, 6'h15, 2, 3);
    run_instr(C_LW, 6'h23, 6'h00, 2, -1);
    run_instr(C_R, 6'h00, 6'h22, 2, -1);
    run_instr(C_R, 6'h00, 6'h2A, 2, -1);
    run_instr(C_BEQ, 6'h04, 6'h3F, 1, -1);
    run_instr(C_BEQ, 6'h04, 6'h00, 0, -1);
    run_instr(C_J, 6'h02, 6'h11, 2, -1);
    run_instr(C_SW, 6'h2B, 6'h2A, 2, -1);
    run_instr(C_ADDI, 6'h08, 6'h22, 2, -1);
    run_instr(C_ILL, 6'h3F, 6'h20, 2, -1);
    run_instr(C_ILL, 6'h00, 6'h00, 2, -1);
    run_instr(C_R, 6'h00, 6'h24, 2, -1);
    run_instr(C_R, 6'h00, 6'h25, 2, -1);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 7);
      f   = 6'($urandom_range(0, 63));
      case (sel)
        0: run_instr(C_LW, 6'h23, f, 2, -1);
        1: run_instr(C_SW, 6'h2B, f, 2, -1);
        2: run_instr(C_R, 6'h00, legal_f[$urandom_range(0, 4)], 2, -1);
        3: run_instr(C_ADDI, 6'h08, f, 2, -1);
        4: run_instr(C_BEQ, 6'h04, f, 2, -1);
        5: run_instr(C_J, 6'h02, f, 2, -1);
        6: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
                 op == 6'h08 || op == 6'h02) op = 6'($urandom_range(0, 63));
          run_instr(C_ILL, op, f, 2, -1);
        end
        default: begin
          while (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A)
            f = 6'($urandom_range(0, 63));
          run_instr(C_ILL, 6'h00, f, 2, -1);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
